// File: rtl/rr_grant_scheduler.sv
// Four-requester round-robin scheduler with a one-hot grant decoded from a registered index/valid pair.
// Optional hold-time limit with a timeout pulse is compiled in by defining RR_GRANT_TIMEOUT_EN.
module rr_grant_scheduler #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_in,
   output logic [3:0] gnt_out,
   output logic [1:0] gnt_idx_out,
   output logic       gnt_valid_out,
   output logic       timeout_out
);

   // Handshake: a requester raises req_in[i] and keeps it high while it owns the
   // resource; gnt_out[i] high means ownership, and dropping req_in[i] ends it.
   typedef enum logic {IDLE, GRANT} state_t;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_grant_scheduler: MAX_HOLD must be within 1..255");
   end

   state_t     state, state_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [1:0] idx_q, idx_nxt;
   logic       to_q, to_nxt;
   logic [1:0] pick_idx;
   logic       pick_found;

   // Scan from the farthest offset down so the nearest set bit to ptr wins.
   always_comb begin
      pick_idx   = ptr;
      pick_found = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (req_in[ptr + 2'(i)]) begin
            pick_idx   = ptr + 2'(i);
            pick_found = 1'b1;
         end
      end
   end

`ifdef RR_GRANT_TIMEOUT_EN
   logic [7:0] hold_cnt, hold_nxt;
`endif

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      idx_nxt   = idx_q;
      to_nxt    = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_nxt  = hold_cnt;
`endif
      case (state)
         IDLE: begin
            if (pick_found) begin
               idx_nxt   = pick_idx;
               state_nxt = GRANT;
`ifdef RR_GRANT_TIMEOUT_EN
               hold_nxt  = 8'd0;
`endif
            end
         end
         GRANT: begin
            if (!req_in[idx_q]) begin
               state_nxt = IDLE;
               ptr_nxt   = idx_q + 2'd1;
            end
`ifdef RR_GRANT_TIMEOUT_EN
            else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
               state_nxt = IDLE;
               ptr_nxt   = idx_q + 2'd1;
               to_nxt    = 1'b1;
            end else begin
               hold_nxt = hold_cnt + 8'd1;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 2'd0;
         idx_q <= 2'd0;
         to_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         idx_q <= idx_nxt;
         to_q  <= to_nxt;
      end
   end

`ifdef RR_GRANT_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) hold_cnt <= 8'd0;
      else     hold_cnt <= hold_nxt;
   end
`endif

   assign gnt_valid_out = (state == GRANT);
   assign gnt_idx_out   = idx_q;
   assign timeout_out   = to_q;
   assign gnt_out       = gnt_valid_out ? (4'b0001 << idx_q) : 4'b0000;

endmodule

// File: doc/rr_grant_scheduler.md
# rr_grant_scheduler

Four-requester round-robin scheduler for one shared resource. It takes up to four request lines and grants exactly one requester at a time. The grant is produced as a 2-bit index plus a valid bit, and that pair is decoded to a one-hot grant vector using 2-to-4 decoder semantics: `y_out = 1 << d_in` when enabled, else `0`. The block sits between requesters and the resource's select/enable inputs and owns all sequencing of access.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may be held. Legal range 1..255. Used only when the timeout is compiled in.
- `clk`  in  1: rising-edge clock; all state changes on this edge.
- `rst`  in  1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `req_in`  in  4: request per requester. A requester holds its bit high until done.
- `gnt_out`  out  4: one-hot grant. Equals decode(`gnt_idx_out`) when `gnt_valid_out` is 1, else 4'b0000.
- `gnt_idx_out`  out  2: index of the current or last granted requester.
- `gnt_valid_out`  out  1: a grant is active.
- `timeout_out`  out  1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- State `ptr[1:0]` is the highest-priority index.
- State `hold_cnt[7:0]` counts cycles spent in GRANT.
- FSM states are IDLE and GRANT.
- IDLE:
  - If `req_in != 0`, choose the first set bit scanning `ptr, ptr+1, ... ptr+3` (mod 4).
  - Register it into `gnt_idx_out`, set `gnt_valid_out`, clear `hold_cnt`, and go to GRANT.
  - Else stay in IDLE.
- GRANT, each cycle:
  - If `req_in[gnt_idx_out]` is 0: clear `gnt_valid_out`, set `ptr = gnt_idx_out + 1` (mod 4, 3 wraps to 0), go to IDLE.
  - Else if the timeout is compiled in and `hold_cnt == MAX_HOLD-1`: same release as above, plus `timeout_out = 1` for that one cycle.
  - Else increment `hold_cnt` and stay in GRANT.
- Requests from non-granted requesters never affect the current grant.
- Requests are level-sensitive and not latched; a request that drops before arbitration is lost.
- `gnt_idx_out` keeps the last granted index while `gnt_valid_out` is 0. `gnt_out` is 0 in that case.
- `gnt_out` is combinational from the registered index and valid bit, so it is glitch-free relative to `clk`.

## Timing
- Reset values: `gnt_out = 0`, `gnt_idx_out = 0`, `gnt_valid_out = 0`, `timeout_out = 0`. Internally, `ptr = 0`, `hold_cnt = 0`, state IDLE.
- `rst` overrides everything, including a grant in progress. The grant drops at the first edge with `rst` high.
- Arbitration resumes at the first edge after `rst` falls.
- Grant latency: a request sampled in IDLE at edge k shows `gnt_out` valid after edge k.
- Release latency: `req_in[idx]` sampled low at edge k gives `gnt_out = 0` after edge k.
- Back-to-back grants always have at least one idle cycle (IDLE) between them.
- A grant lasts at least 1 cycle. With the timeout, it lasts at most `MAX_HOLD` cycles.
- `timeout_out` is high only in the cycle where `gnt_valid_out` has just fallen due to timeout. It is never high for two consecutive cycles.
- Simultaneous release and timeout: a release by request drop takes priority, and `timeout_out` stays 0.

## Configuration
- Macro: `RR_GRANT_TIMEOUT_EN`.
- Defined: the `hold_cnt` limit is enforced and `timeout_out` pulses as described above.
- Undefined:
  - `hold_cnt` and the limit logic are removed and `MAX_HOLD` is ignored.
  - A grant is held until its request drops.
  - `timeout_out` is tied to 0.

## Test plan
- Reset: `rst = 1` for 2 cycles with `req_in = 4'b1111` gives all outputs 0 throughout. After release, `gnt_out = 4'b0001` one edge later.
- Single request: `req_in = 4'b0100` gives `gnt_out = 4'b0100` and `gnt_idx_out = 2` after one edge. Dropping the request gives `gnt_out = 0` after one edge, with `gnt_idx_out` still 2.
- Rotation: all four requesters each hold their request 3 grant cycles, then re-request. Grants appear in order 0001, 0010, 0100, 1000, 0001, each separated by one zero cycle.
- Wrap: after a grant to index 2 is released (`ptr = 3`), `req_in = 4'b0011` gives a grant to 0 (4'b0001), not 1.
- Timeout (macro on, `MAX_HOLD = 8`): `req_in = 4'b1111` held constant.
  - Each grant lasts exactly 8 cycles.
  - `timeout_out` pulses once at each revocation.
  - Order is 0, 1, 2, 3, 0.
  - With the macro off, `gnt_out` stays 4'b0001 indefinitely.
- Reset mid-grant: `rst` pulsed for 1 cycle during cycle 3 of a grant to index 1.
  - Outputs are 0 on the next edge.
  - With `req_in = 4'b0010` still high, the grant to index 1 returns one edge after `rst` falls, and `ptr` has been reset to 0.
